// File: rtl/demux_pkg.sv
// Shared constants and types for the 4-lane byte striping demultiplexer.
package demux_pkg;

  localparam int NUM_LANES = 4;

  typedef logic [1:0] lane_idx_t;

  localparam logic [7:0] PAD_BYTE_DEFAULT = 8'hF7;

endpackage

// File: rtl/lane_reg.sv
// 8-bit register with load enable and asynchronous active-low reset.
module lane_reg #(
  parameter int W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         i_load,
  input  logic [W-1:0] i_d,
  output logic [W-1:0] o_q
);

  logic [W-1:0] r_q;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset)      r_q <= '0;
    else if (i_load) r_q <= i_d;
  end

  assign o_q = r_q;

endmodule

// File: rtl/byte_stripe_demux4.sv
// Stripes a byte stream round-robin across four lanes and emits complete groups.
// Optional flush of a partial group (padded with PAD_BYTE) under macro DEMUX_FLUSH_EN.
module byte_stripe_demux4
  import demux_pkg::*;
#(
  parameter logic [7:0] PAD_BYTE = PAD_BYTE_DEFAULT
) (
  input  logic      clk,
  input  logic      reset,
  input  logic [7:0] in,
  input  logic      valid_in,
`ifdef DEMUX_FLUSH_EN
  input  logic      flush,
`endif
  output logic [7:0] out0,
  output logic [7:0] out1,
  output logic [7:0] out2,
  output logic [7:0] out3,
  output logic      valid_out,
  output lane_idx_t lane_ptr
);

  lane_idx_t r_ptr;
  lane_idx_t w_ptr_nxt;
  logic      r_valid;
  logic      w_flush;
  logic      w_emit;

  logic [NUM_LANES-1:0][7:0] w_stage;
  logic [NUM_LANES-1:0][7:0] w_grp;
  logic [NUM_LANES-1:0][7:0] w_out;

`ifdef DEMUX_FLUSH_EN
  assign w_flush = flush;
`else
  assign w_flush = 1'b0;
`endif

  // A group goes out when the 4th byte lands, or on flush if anything is pending.
  assign w_emit = (valid_in && (r_ptr == lane_idx_t'(NUM_LANES - 1)))
                || (w_flush && (valid_in || (r_ptr != '0)));

  always_comb begin
    w_ptr_nxt = r_ptr;
    if (w_emit)        w_ptr_nxt = '0;
    else if (valid_in) w_ptr_nxt = r_ptr + lane_idx_t'(1);
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ptr   <= '0;
      r_valid <= 1'b0;
    end else begin
      r_ptr   <= w_ptr_nxt;
      r_valid <= w_emit;
    end
  end

  for (genvar k = 0; k < NUM_LANES; k++) begin : g_lane
    lane_reg #(.W(8)) u_stage (
      .clk    (clk),
      .reset  (reset),
      .i_load (valid_in && (r_ptr == lane_idx_t'(k))),
      .i_d    (in),
      .o_q    (w_stage[k])
    );

    // Lanes already filled come from staging; the current byte bypasses staging.
    assign w_grp[k] = (lane_idx_t'(k) < r_ptr)                    ? w_stage[k] :
                      ((lane_idx_t'(k) == r_ptr) && valid_in)     ? in         :
                                                                     PAD_BYTE;

    lane_reg #(.W(8)) u_out (
      .clk    (clk),
      .reset  (reset),
      .i_load (w_emit),
      .i_d    (w_grp[k]),
      .o_q    (w_out[k])
    );
  end

  assign out0      = w_out[0];
  assign out1      = w_out[1];
  assign out2      = w_out[2];
  assign out3      = w_out[3];
  assign valid_out = r_valid;
  assign lane_ptr  = r_ptr;

endmodule

// File: tb/tb_byte_stripe_demux4.sv
// Directed bench for byte_stripe_demux4 with a queue-based group model.
// Flush scenarios are included when DEMUX_FLUSH_EN is defined.
module tb_byte_stripe_demux4;

  logic       clk;
  logic       reset;
  logic [7:0] dataIn;
  logic       validIn;
  logic       flushIn;
  logic [7:0] out0, out1, out2, out3;
  logic       validOut;
  logic [1:0] lanePtr;

  int checks;
  int fails;
  bit checkEn;

  logic [7:0] pending[$];
  logic [7:0] mOut[4];
  bit         mValid;

  byte_stripe_demux4 dut (
    .clk       (clk),
    .reset     (reset),
    .in        (dataIn),
    .valid_in  (validIn),
`ifdef DEMUX_FLUSH_EN
    .flush     (flushIn),
`endif
    .out0      (out0),
    .out1      (out1),
    .out2      (out2),
    .out3      (out3),
    .valid_out (validOut),
    .lane_ptr  (lanePtr)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Model: bytes accumulate in a queue; a full queue (or a flush) becomes a padded group.
  always @(posedge clk or negedge reset) begin
    if (!reset) begin
      pending.delete();
      for (int i = 0; i < 4; i++) mOut[i] = 8'h00;
      mValid = 1'b0;
    end else begin
      mValid = 1'b0;
      if (validIn) pending.push_back(dataIn);
      if (pending.size() == 4 || (flushIn && pending.size() > 0)) begin
        for (int i = 0; i < 4; i++) mOut[i] = (i < pending.size()) ? pending[i] : 8'hF7;
        mValid = 1'b1;
        pending.delete();
      end
    end
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Every negedge compares the DUT against the model.
  always @(negedge clk) begin
    if (checkEn) begin
      checkOutput("model.out0", {24'h0, out0}, {24'h0, mOut[0]});
      checkOutput("model.out1", {24'h0, out1}, {24'h0, mOut[1]});
      checkOutput("model.out2", {24'h0, out2}, {24'h0, mOut[2]});
      checkOutput("model.out3", {24'h0, out3}, {24'h0, mOut[3]});
      checkOutput("model.valid_out", {31'h0, validOut}, {31'h0, mValid});
      checkOutput("model.lane_ptr", {30'h0, lanePtr}, pending.size());
    end
  end

  // Drives one cycle of inputs; returns 2 time units after the edge that sampled them.
  task automatic applyStimulus(input logic v, input logic [7:0] b, input logic f);
    validIn = v;
    dataIn  = b;
    flushIn = f;
    @(posedge clk);
    #2;
    validIn = 1'b0;
    flushIn = 1'b0;
  endtask

  task automatic checkGroup(input string name, input logic [7:0] e0, input logic [7:0] e1,
                            input logic [7:0] e2, input logic [7:0] e3, input logic ev);
    checkOutput({name, ".out0"}, {24'h0, out0}, {24'h0, e0});
    checkOutput({name, ".out1"}, {24'h0, out1}, {24'h0, e1});
    checkOutput({name, ".out2"}, {24'h0, out2}, {24'h0, e2});
    checkOutput({name, ".out3"}, {24'h0, out3}, {24'h0, e3});
    checkOutput({name, ".valid"}, {31'h0, validOut}, {31'h0, ev});
  endtask

  initial begin
    logic [7:0] seq[8];
    checks  = 0;
    fails   = 0;
    checkEn = 1'b0;
    reset   = 1'b0;
    dataIn  = 8'h00;
    validIn = 1'b0;
    flushIn = 1'b0;

    #1;
    checkGroup("reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("reset.lane_ptr", {30'h0, lanePtr}, 32'd0);
    #12 reset = 1'b1;
    @(posedge clk);
    #2;
    checkEn = 1'b1;

    // Basic group
    applyStimulus(1'b1, 8'h11, 1'b0);
    applyStimulus(1'b1, 8'h22, 1'b0);
    applyStimulus(1'b1, 8'h33, 1'b0);
    applyStimulus(1'b1, 8'h44, 1'b0);
    checkGroup("basic", 8'h11, 8'h22, 8'h33, 8'h44, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkGroup("basic.hold", 8'h11, 8'h22, 8'h33, 8'h44, 1'b0);

    // Gap of three idle cycles mid-group
    applyStimulus(1'b1, 8'hA1, 1'b0);
    applyStimulus(1'b1, 8'hA2, 1'b0);
    for (int i = 0; i < 3; i++) begin
      applyStimulus(1'b0, 8'hEE, 1'b0);
      checkOutput("gap.lane_ptr", {30'h0, lanePtr}, 32'd2);
    end
    applyStimulus(1'b1, 8'hA3, 1'b0);
    applyStimulus(1'b1, 8'hA4, 1'b0);
    checkGroup("gap", 8'hA1, 8'hA2, 8'hA3, 8'hA4, 1'b1);

    // Back-to-back stream of two groups
    seq = '{8'h01, 8'h02, 8'h03, 8'h04, 8'h05, 8'h06, 8'h07, 8'h08};
    for (int i = 0; i < 8; i++) begin
      applyStimulus(1'b1, seq[i], 1'b0);
      if (i == 2) checkOutput("stream.lane_ptr3", {30'h0, lanePtr}, 32'd3);
      if (i == 3) begin
        checkGroup("stream.g0", 8'h01, 8'h02, 8'h03, 8'h04, 1'b1);
        checkOutput("stream.wrap", {30'h0, lanePtr}, 32'd0);
      end
      if (i == 5) checkOutput("stream.mid_valid", {31'h0, validOut}, 32'd0);
    end
    checkGroup("stream.g1", 8'h05, 8'h06, 8'h07, 8'h08, 1'b1);

    // Asynchronous reset mid-group
    applyStimulus(1'b1, 8'h5A, 1'b0);
    applyStimulus(1'b1, 8'h5B, 1'b0);
    #1 reset = 1'b0;
    #1;
    checkGroup("async_reset", 8'h00, 8'h00, 8'h00, 8'h00, 1'b0);
    checkOutput("async_reset.lane_ptr", {30'h0, lanePtr}, 32'd0);
    @(posedge clk);
    #2 reset = 1'b1;
    applyStimulus(1'b1, 8'hC0, 1'b0);
    applyStimulus(1'b1, 8'hC1, 1'b0);
    applyStimulus(1'b1, 8'hC2, 1'b0);
    applyStimulus(1'b1, 8'hC3, 1'b0);
    checkGroup("post_reset", 8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b1);

`ifdef DEMUX_FLUSH_EN
    // Flush of a one-byte partial group
    applyStimulus(1'b1, 8'h77, 1'b0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkGroup("flush", 8'h77, 8'hF7, 8'hF7, 8'hF7, 1'b1);
    checkOutput("flush.lane_ptr", {30'h0, lanePtr}, 32'd0);
    applyStimulus(1'b0, 8'h00, 1'b1);
    checkGroup("flush.idle", 8'h77, 8'hF7, 8'hF7, 8'hF7, 1'b0);

    // Flush coinciding with the completing byte
    applyStimulus(1'b1, 8'h10, 1'b0);
    applyStimulus(1'b1, 8'h20, 1'b0);
    applyStimulus(1'b1, 8'h30, 1'b0);
    applyStimulus(1'b1, 8'h40, 1'b1);
    checkGroup("flush_full", 8'h10, 8'h20, 8'h30, 8'h40, 1'b1);
    applyStimulus(1'b0, 8'h00, 1'b0);
    checkGroup("flush_full.no_pad", 8'h10, 8'h20, 8'h30, 8'h40, 1'b0);
`else
    // Partial group waits indefinitely without flush support
    applyStimulus(1'b1, 8'h77, 1'b0);
    for (int i = 0; i < 5; i++) applyStimulus(1'b0, 8'h00, 1'b0);
    checkGroup("partial_wait", 8'hC0, 8'hC1, 8'hC2, 8'hC3, 1'b0);
    checkOutput("partial_wait.lane_ptr", {30'h0, lanePtr}, 32'd1);
`endif

    applyStimulus(1'b0, 8'h00, 1'b0);
    checkEn = 1'b0;
    $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
    $finish;
  end

endmodule

// File: doc/byte_stripe_demux4.md
BYTE_STRIPE_DEMUX4 -- requirements
Module: byte_stripe_demux4

Interface
REQ-001 SHALL have parameter: PAD_BYTE, 8'hF7, fill value for padded lanes on flush.
REQ-002 SHALL have port: clk  input  1  sole clock; all state changes on posedge.
REQ-003 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-004 SHALL have port: in  input  8  byte from upstream register stage.
REQ-005 SHALL have port: valid_in  input  1  in carries a valid byte this cycle.
REQ-006 SHALL have ports: out0, out1, out2, out3  output  8 each  lane bytes, registered.
REQ-007 SHALL have port: valid_out  output  1  one-cycle pulse; out0..out3 hold a complete group.
REQ-008 SHALL have port: lane_ptr  output  2  index of the lane the next valid byte fills.
REQ-009 SHALL have port, only under DEMUX_FLUSH_EN: flush  input  1  close the partial group.

Function
REQ-010 SHALL stripe valid bytes round-robin: 1st byte of a group to lane 0, 2nd to lane 1, 3rd to lane 2, 4th to lane 3.
REQ-011 SHALL capture each valid byte into an internal staging register for its lane and advance lane_ptr by 1 modulo 4.
REQ-012 SHALL, on the edge sampling the 4th valid byte, load out0..out3 with the complete group and assert valid_out in the following cycle, for a latency of 1 clk.
REQ-013 SHALL hold lane_ptr and staging contents when valid_in=0; gaps between bytes are legal.
REQ-014 SHALL wrap lane_ptr from 3 to 0 when a group completes.
REQ-015 SHALL sustain one byte per clk, so back-to-back groups produce valid_out every 4th cycle.
REQ-016 SHALL hold out0..out3 stable between groups; valid_out SHALL deassert after one cycle.
REQ-017 SHALL drive lane_ptr equal to the internal pointer register.

Reset
REQ-018 SHALL, when reset=0 at any time, immediately clear out0..out3 to 8'h00, valid_out to 0, lane_ptr to 0, and all staging registers to 8'h00.
REQ-019 SHALL discard any partial group when reset asserts mid-group; after release the first valid byte goes to lane 0.

Configuration
REQ-020 SHALL compile the flush feature only when macro DEMUX_FLUSH_EN is defined.
REQ-021 With DEMUX_FLUSH_EN defined and lane_ptr≠0, flush=1 SHALL emit the partial group with unfilled lanes set to PAD_BYTE, pulse valid_out next cycle, and reset lane_ptr to 0.
REQ-022 With DEMUX_FLUSH_EN defined, flush=1 and valid_in=1 in the same cycle SHALL place the byte first, then pad the remaining lanes; if that byte completes the group, a normal group SHALL be emitted with no extra group.
REQ-023 With DEMUX_FLUSH_EN defined, flush=1 with lane_ptr=0 and valid_in=0 SHALL have no effect.
REQ-024 Without DEMUX_FLUSH_EN, the flush port SHALL be absent and partial groups SHALL wait indefinitely for more bytes.

Structure
REQ-025 SHALL place NUM_LANES=4, the 2-bit lane index typedef and the default PAD_BYTE constant in shared package demux_pkg.
REQ-026 SHALL instantiate sub-module lane_reg (8-bit register with load enable and async active-low reset) for each staging and output register.

Verification
REQ-027 Bench SHALL drive reset release, then bytes 8'h11,22,33,44 on 4 consecutive cycles -> one cycle later out0..3 = 11,22,33,44, valid_out=1 for exactly 1 cycle.
REQ-028 Bench SHALL drive bytes A1,A2 with a 3-cycle valid_in gap, then A3,A4 -> a single group A1..A4, lane_ptr = 2 throughout the gap.
REQ-029 Bench SHALL stream 8 back-to-back bytes 01..08 -> valid_out pulses 4 cycles apart with groups 01..04 and 05..08; lane_ptr wraps 3->0.
REQ-030 Bench SHALL drive bytes 5A,5B, then assert reset asynchronously between edges, release it, then send C0..C3 -> all outputs 0 immediately at reset assertion, next group C0..C3 with no 5A/5B.
REQ-031 Bench SHALL, with DEMUX_FLUSH_EN defined, drive byte 77 followed by flush=1 -> out0..3 = 77,F7,F7,F7 with valid_out pulse and lane_ptr=0.
REQ-032 Bench SHALL, with DEMUX_FLUSH_EN defined, drive bytes 10,20,30 then byte 40 with flush=1 in the same cycle -> exactly one group 10,20,30,40 and no padded group.
